// File: rtl/pipe_controller_if.sv
// Control-side bundle between the 5-stage datapath/hazard unit (master) and pipe_controller (slave).
// Parameters must match the ones given to pipe_controller.
interface pipe_controller_if #(
  parameter int ALUC_W = 3,
  parameter int IMM_W  = 3,
  parameter int CNT_W  = 32
);
  logic [6:0]        op_d;
  logic [2:0]        func3_d;
  logic [6:0]        func7_d;
  logic              valid_d;
  logic              flush_e;
  logic              zero_e;
  logic              lt_e;

  logic [IMM_W-1:0]  imm_src_d;
  logic [ALUC_W-1:0] alu_control_e;
  logic              alu_src_e;
  logic              jalr_e;
  logic              pc_src_e;
  logic              result_src_e0;
  logic              reg_write_m;
  logic              mem_write_m;
  logic [1:0]        result_src_m;
  logic              reg_write_w;
  logic [1:0]        result_src_w;
  logic [CNT_W-1:0]  retired_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output op_d, func3_d, func7_d, valid_d, flush_e, zero_e, lt_e,
    input  imm_src_d, alu_control_e, alu_src_e, jalr_e, pc_src_e, result_src_e0,
           reg_write_m, mem_write_m, result_src_m, reg_write_w, result_src_w,
           retired_cnt, flush_cnt
  );

  modport slave (
    input  op_d, func3_d, func7_d, valid_d, flush_e, zero_e, lt_e,
    output imm_src_d, alu_control_e, alu_src_e, jalr_e, pc_src_e, result_src_e0,
           reg_write_m, mem_write_m, result_src_m, reg_write_w, result_src_w,
           retired_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined control unit: decode in D, control bundle carried through ID/EX, EX/MEM, MEM/WB.
// Optional retired/flush counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_controller #(
  parameter int ALUC_W = 3,
  parameter int IMM_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipe_controller_if.slave bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;

  logic [2:0] alu3;
  logic [2:0] imm3;
  logic [1:0] dec_result_src;
  logic       dec_known;
  logic       dec_reg_write;
  logic       dec_mem_write;
  logic       dec_jump;
  logic       dec_branch;
  logic       dec_alu_src;
  logic       dec_jalr;
  logic       dec_valid;

  always_comb begin
    alu3           = 3'b000;
    imm3           = 3'b000;
    dec_result_src = 2'b00;
    dec_known      = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_jump       = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_src    = 1'b0;
    dec_jalr       = 1'b0;
    case (bus.op_d)
      OP_R: begin
        dec_known     = 1'b1;
        dec_reg_write = 1'b1;
        case (bus.func3_d)
          3'b000:  alu3 = (bus.func7_d == 7'b0100000) ? 3'b110 : 3'b010;
          3'b111:  alu3 = 3'b000;
          3'b110:  alu3 = 3'b001;
          3'b010:  alu3 = 3'b100;
          3'b011:  alu3 = 3'b111;
          default: alu3 = 3'b000;
        endcase
      end
      OP_LOAD: begin
        dec_known      = 1'b1;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b01;
        dec_alu_src    = 1'b1;
      end
      OP_I: begin
        dec_known     = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        case (bus.func3_d)
          3'b000:  alu3 = 3'b010;
          3'b100:  alu3 = 3'b011;
          3'b110:  alu3 = 3'b001;
          3'b010:  alu3 = 3'b100;
          3'b011: begin
            alu3 = 3'b111;
            imm3 = 3'b101;
          end
          default: alu3 = 3'b000;
        endcase
      end
      OP_JALR: begin
        dec_known      = 1'b1;
        dec_jalr       = 1'b1;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b10;
        dec_reg_write  = 1'b1;
      end
      OP_S: begin
        dec_known     = 1'b1;
        imm3          = 3'b001;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_J: begin
        dec_known      = 1'b1;
        dec_result_src = 2'b10;
        imm3           = 3'b011;
        dec_reg_write  = 1'b1;
        dec_jump       = 1'b1;
      end
      OP_B: begin
        dec_known  = 1'b1;
        dec_branch = 1'b1;
        imm3       = 3'b010;
        case (bus.func3_d)
          3'b000, 3'b001: alu3 = 3'b110;
          3'b100, 3'b101: alu3 = 3'b111;
          default:        alu3 = 3'b000;
        endcase
      end
      OP_U: begin
        dec_known      = 1'b1;
        dec_result_src = 2'b11;
        imm3           = 3'b100;
        dec_reg_write  = 1'b1;
      end
      default: dec_known = 1'b0;
    endcase
    // An unknown opcode is demoted to a bubble so nothing downstream acts on it.
    dec_valid = bus.valid_d & dec_known;
  end

  assign bus.imm_src_d = dec_valid ? IMM_W'(imm3) : '0;

  // ID/EX: the whole bundle is zero for bubbles, so later stages need no extra gating.
  logic              valid_e_reg,       valid_e_next;
  logic              reg_write_e_reg,   reg_write_e_next;
  logic              mem_write_e_reg,   mem_write_e_next;
  logic              jump_e_reg,        jump_e_next;
  logic              branch_e_reg,      branch_e_next;
  logic              alu_src_e_reg,     alu_src_e_next;
  logic              jalr_e_reg,        jalr_e_next;
  logic [1:0]        result_src_e_reg,  result_src_e_next;
  logic [ALUC_W-1:0] alu_control_e_reg, alu_control_e_next;
  logic [2:0]        func3_e_reg,       func3_e_next;

  always_comb begin
    valid_e_next       = 1'b0;
    reg_write_e_next   = 1'b0;
    mem_write_e_next   = 1'b0;
    jump_e_next        = 1'b0;
    branch_e_next      = 1'b0;
    alu_src_e_next     = 1'b0;
    jalr_e_next        = 1'b0;
    result_src_e_next  = 2'b00;
    alu_control_e_next = '0;
    func3_e_next       = 3'b000;
    if (!bus.flush_e && dec_valid) begin
      valid_e_next       = 1'b1;
      reg_write_e_next   = dec_reg_write;
      mem_write_e_next   = dec_mem_write;
      jump_e_next        = dec_jump;
      branch_e_next      = dec_branch;
      alu_src_e_next     = dec_alu_src;
      jalr_e_next        = dec_jalr;
      result_src_e_next  = dec_result_src;
      alu_control_e_next = ALUC_W'(alu3);
      func3_e_next       = bus.func3_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e_reg       <= 1'b0;
      reg_write_e_reg   <= 1'b0;
      mem_write_e_reg   <= 1'b0;
      jump_e_reg        <= 1'b0;
      branch_e_reg      <= 1'b0;
      alu_src_e_reg     <= 1'b0;
      jalr_e_reg        <= 1'b0;
      result_src_e_reg  <= 2'b00;
      alu_control_e_reg <= '0;
      func3_e_reg       <= 3'b000;
    end else begin
      valid_e_reg       <= valid_e_next;
      reg_write_e_reg   <= reg_write_e_next;
      mem_write_e_reg   <= mem_write_e_next;
      jump_e_reg        <= jump_e_next;
      branch_e_reg      <= branch_e_next;
      alu_src_e_reg     <= alu_src_e_next;
      jalr_e_reg        <= jalr_e_next;
      result_src_e_reg  <= result_src_e_next;
      alu_control_e_reg <= alu_control_e_next;
      func3_e_reg       <= func3_e_next;
    end
  end

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (func3_e_reg)
      3'b000:  taken = bus.zero_e;
      3'b001:  taken = ~bus.zero_e;
      3'b100:  taken = bus.lt_e;
      3'b101:  taken = ~bus.lt_e;
      default: taken = 1'b0;
    endcase
  end

  assign bus.pc_src_e      = valid_e_reg & ((branch_e_reg & taken) | jump_e_reg | jalr_e_reg);
  assign bus.alu_control_e = alu_control_e_reg;
  assign bus.alu_src_e     = alu_src_e_reg;
  assign bus.jalr_e        = jalr_e_reg;
  assign bus.result_src_e0 = result_src_e_reg[0];

  logic       reg_write_m_reg;
  logic       mem_write_m_reg;
  logic [1:0] result_src_m_reg;
  logic       reg_write_w_reg;
  logic [1:0] result_src_w_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m_reg  <= 1'b0;
      mem_write_m_reg  <= 1'b0;
      result_src_m_reg <= 2'b00;
      reg_write_w_reg  <= 1'b0;
      result_src_w_reg <= 2'b00;
    end else begin
      reg_write_m_reg  <= reg_write_e_reg;
      mem_write_m_reg  <= mem_write_e_reg;
      result_src_m_reg <= result_src_e_reg;
      reg_write_w_reg  <= reg_write_m_reg;
      result_src_w_reg <= result_src_m_reg;
    end
  end

  assign bus.reg_write_m  = reg_write_m_reg;
  assign bus.mem_write_m  = mem_write_m_reg;
  assign bus.result_src_m = result_src_m_reg;
  assign bus.reg_write_w  = reg_write_w_reg;
  assign bus.result_src_w = result_src_w_reg;

`ifdef PIPE_CTRL_PERF_EN
  // valid only needs to travel past E when something counts retirements.
  logic             valid_m_reg;
  logic             valid_w_reg;
  logic [CNT_W-1:0] retired_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m_reg     <= 1'b0;
      valid_w_reg     <= 1'b0;
      retired_cnt_reg <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      valid_m_reg <= valid_e_reg;
      valid_w_reg <= valid_m_reg;
      if (valid_w_reg)
        retired_cnt_reg <= retired_cnt_reg + 1'b1;
      if (bus.flush_e && bus.valid_d)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.retired_cnt = retired_cnt_reg;
  assign bus.flush_cnt   = flush_cnt_reg;
`else
  assign bus.retired_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: an instruction-table reference model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_pipe_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_controller_if bus ();
  pipe_controller dut (.clk(clk), .rst(rst), .bus(bus));

  // One row per mnemonic: encoding plus the control values it must produce.
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       rw;
    logic [1:0] rs;
    logic       asrc;
    logic       mw;
    logic       jr;
    logic       br;
    logic       jp;
    logic       known;
  } ent_t;

  typedef struct packed {
    logic       v;
    logic [2:0] f3;
    logic [2:0] alu;
    logic       asrc;
    logic       jr;
    logic       br;
    logic       jp;
    logic       rw;
    logic       mw;
    logic [1:0] rs;
  } stage_t;

  typedef struct packed {
    logic [2:0]  alu;
    logic        asrc;
    logic        jr;
    logic        pc;
    logic        rse0;
    logic        rwm;
    logic        mwm;
    logic [1:0]  rsm;
    logic        rww;
    logic [1:0]  rsw;
    logic [2:0]  imm;
    logic [31:0] ret;
    logic [31:0] fl;
  } exp_t;

  localparam int NTBL = 22;
  ent_t        tbl [NTBL];
  stage_t      m_e, m_m, m_w;
  int unsigned ret_m, fl_m;
  exp_t        sb [$];
  exp_t        mx;
  int          total = 0;
  int          bad   = 0;
  int          txn   = 0;

  function automatic ent_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [2:0] alu, input logic [2:0] imm, input logic rw,
                              input logic [1:0] rs, input logic asrc, input logic mw,
                              input logic jr, input logic br, input logic jp, input logic known);
    ent_t e;
    e = '{op:op, f3:f3, f7:f7, alu:alu, imm:imm, rw:rw, rs:rs, asrc:asrc, mw:mw,
          jr:jr, br:br, jp:jp, known:known};
    return e;
  endfunction

  task automatic init_tbl();
    tbl[0]  = mk(7'b0110011, 3'd0, 7'h00, 3'b010, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 1); // add
    tbl[1]  = mk(7'b0110011, 3'd0, 7'h20, 3'b110, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 1); // sub
    tbl[2]  = mk(7'b0110011, 3'd7, 7'h00, 3'b000, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 1); // and
    tbl[3]  = mk(7'b0110011, 3'd6, 7'h00, 3'b001, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 1); // or
    tbl[4]  = mk(7'b0110011, 3'd2, 7'h00, 3'b100, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 1); // slt
    tbl[5]  = mk(7'b0110011, 3'd3, 7'h00, 3'b111, 3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 1); // sltu
    tbl[6]  = mk(7'b0000011, 3'd2, 7'h00, 3'b000, 3'b000, 1, 2'b01, 1, 0, 0, 0, 0, 1); // lw
    tbl[7]  = mk(7'b0010011, 3'd0, 7'h00, 3'b010, 3'b000, 1, 2'b00, 1, 0, 0, 0, 0, 1); // addi
    tbl[8]  = mk(7'b0010011, 3'd4, 7'h00, 3'b011, 3'b000, 1, 2'b00, 1, 0, 0, 0, 0, 1); // xori
    tbl[9]  = mk(7'b0010011, 3'd6, 7'h00, 3'b001, 3'b000, 1, 2'b00, 1, 0, 0, 0, 0, 1); // ori
    tbl[10] = mk(7'b0010011, 3'd2, 7'h00, 3'b100, 3'b000, 1, 2'b00, 1, 0, 0, 0, 0, 1); // slti
    tbl[11] = mk(7'b0010011, 3'd3, 7'h00, 3'b111, 3'b101, 1, 2'b00, 1, 0, 0, 0, 0, 1); // sltiu
    tbl[12] = mk(7'b1100111, 3'd0, 7'h00, 3'b000, 3'b000, 1, 2'b10, 1, 0, 1, 0, 0, 1); // jalr
    tbl[13] = mk(7'b0100011, 3'd2, 7'h00, 3'b000, 3'b001, 0, 2'b00, 1, 1, 0, 0, 0, 1); // sw
    tbl[14] = mk(7'b1101111, 3'd0, 7'h00, 3'b000, 3'b011, 1, 2'b10, 0, 0, 0, 0, 1, 1); // jal
    tbl[15] = mk(7'b1100011, 3'd0, 7'h00, 3'b110, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1); // beq
    tbl[16] = mk(7'b1100011, 3'd1, 7'h00, 3'b110, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1); // bne
    tbl[17] = mk(7'b1100011, 3'd4, 7'h00, 3'b111, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1); // blt
    tbl[18] = mk(7'b1100011, 3'd5, 7'h00, 3'b111, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1); // bge
    tbl[19] = mk(7'b0110111, 3'd0, 7'h00, 3'b000, 3'b100, 1, 2'b11, 0, 0, 0, 0, 0, 1); // lui
    tbl[20] = mk(7'b1111111, 3'd0, 7'h00, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0); // unknown
    tbl[21] = mk(7'b0000000, 3'd0, 7'h00, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0); // unknown
  endtask

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_e   = '0;
    m_m   = '0;
    m_w   = '0;
    ret_m = 0;
    fl_m  = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Called just after a rising edge: present D instruction e (latched at the next edge)
  // and zero/lt for whatever sits in E now; record this cycle's expected outputs.
  task automatic step(input ent_t e, input logic v, input logic fl, input logic z, input logic l);
    exp_t   x;
    stage_t ds;
    logic   dv;
    bus.op_d    = e.op;
    bus.func3_d = (e.known) ? e.f3 : 3'($urandom);
    bus.func7_d = (e.op == 7'b0110011) ? e.f7 : 7'($urandom);
    bus.valid_d = v;
    bus.flush_e = fl;
    bus.zero_e  = z;
    bus.lt_e    = l;
    dv = v & e.known;
    ds = dv ? '{v:1'b1, f3:e.f3, alu:e.alu, asrc:e.asrc, jr:e.jr, br:e.br, jp:e.jp,
                rw:e.rw, mw:e.mw, rs:e.rs} : '0;
    x.alu  = m_e.alu;
    x.asrc = m_e.asrc;
    x.jr   = m_e.jr;
    x.pc   = m_e.v & ((m_e.br & br_taken(m_e.f3, z, l)) | m_e.jp | m_e.jr);
    x.rse0 = m_e.rs[0];
    x.rwm  = m_m.rw;
    x.mwm  = m_m.mw;
    x.rsm  = m_m.rs;
    x.rww  = m_w.rw;
    x.rsw  = m_w.rs;
    x.imm  = dv ? e.imm : 3'b000;
`ifdef PIPE_CTRL_PERF_EN
    x.ret  = 32'(ret_m);
    x.fl   = 32'(fl_m);
`else
    x.ret  = 32'd0;
    x.fl   = 32'd0;
`endif
    sb.push_back(x);
    @(posedge clk);
    if (m_w.v) ret_m++;
    if (fl && v) fl_m++;
    m_w = m_m;
    m_m = m_e;
    m_e = fl ? '0 : ds;
    #1;
  endtask

  task automatic nop(input logic z, input logic l);
    step(tbl[0], 1'b0, 1'b0, z, l);
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, ".alu_control_e"}, 32'(bus.alu_control_e), 32'd0);
    chk({tag, ".alu_src_e"},     32'(bus.alu_src_e),     32'd0);
    chk({tag, ".jalr_e"},        32'(bus.jalr_e),        32'd0);
    chk({tag, ".pc_src_e"},      32'(bus.pc_src_e),      32'd0);
    chk({tag, ".result_src_e0"}, 32'(bus.result_src_e0), 32'd0);
    chk({tag, ".reg_write_m"},   32'(bus.reg_write_m),   32'd0);
    chk({tag, ".mem_write_m"},   32'(bus.mem_write_m),   32'd0);
    chk({tag, ".result_src_m"},  32'(bus.result_src_m),  32'd0);
    chk({tag, ".reg_write_w"},   32'(bus.reg_write_w),   32'd0);
    chk({tag, ".result_src_w"},  32'(bus.result_src_w),  32'd0);
    chk({tag, ".retired_cnt"},   32'(bus.retired_cnt),   32'd0);
    chk({tag, ".flush_cnt"},     32'(bus.flush_cnt),     32'd0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, checked before the next edge.
  task automatic mid_reset(input string tag);
    #1 rst = 1'b1;
    #1 chk_regs_zero(tag);
    model_reset();
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      txn++;
      chk("alu_control_e", 32'(bus.alu_control_e), 32'(mx.alu));
      chk("alu_src_e",     32'(bus.alu_src_e),     32'(mx.asrc));
      chk("jalr_e",        32'(bus.jalr_e),        32'(mx.jr));
      chk("pc_src_e",      32'(bus.pc_src_e),      32'(mx.pc));
      chk("result_src_e0", 32'(bus.result_src_e0), 32'(mx.rse0));
      chk("reg_write_m",   32'(bus.reg_write_m),   32'(mx.rwm));
      chk("mem_write_m",   32'(bus.mem_write_m),   32'(mx.mwm));
      chk("result_src_m",  32'(bus.result_src_m),  32'(mx.rsm));
      chk("reg_write_w",   32'(bus.reg_write_w),   32'(mx.rww));
      chk("result_src_w",  32'(bus.result_src_w),  32'(mx.rsw));
      chk("imm_src_d",     32'(bus.imm_src_d),     32'(mx.imm));
      chk("retired_cnt",   32'(bus.retired_cnt),   mx.ret);
      chk("flush_cnt",     32'(bus.flush_cnt),     mx.fl);
      $display("txn %0d alu_e=%0h pc_src=%0b rw_m=%0b rs_m=%0h rw_w=%0b rs_w=%0h imm_d=%0h ret=%0d",
               txn, bus.alu_control_e, bus.pc_src_e, bus.reg_write_m, bus.result_src_m,
               bus.reg_write_w, bus.result_src_w, bus.imm_src_d, bus.retired_cnt);
    end
  end

  initial begin
    init_tbl();
    model_reset();
    rst         = 1'b1;
    bus.op_d    = 7'd0;
    bus.func3_d = 3'd0;
    bus.func7_d = 7'd0;
    bus.valid_d = 1'b0;
    bus.flush_e = 1'b0;
    bus.zero_e  = 1'b0;
    bus.lt_e    = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_regs_zero("por");
    #1 rst = 1'b0;

    // add flows D->E->M->W
    step(tbl[0], 1, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);

    // branches resolved in E: beq taken, beq not taken, bge with lt=0
    step(tbl[15], 1, 0, 0, 0); nop(1, 0);
    step(tbl[15], 1, 0, 0, 0); nop(0, 0);
    step(tbl[18], 1, 0, 0, 0); nop(0, 0);
    step(tbl[16], 1, 0, 0, 0); nop(0, 0);
    step(tbl[17], 1, 0, 0, 0); nop(0, 1);

    // lw bubbled by flush
    step(tbl[6], 1, 1, 0, 0); nop(0, 0); nop(0, 0);

    // jal, then an unknown opcode marked valid
    step(tbl[14], 1, 0, 0, 0);
    step(tbl[20], 1, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);

    // flush while the branch in E redirects: the branch still moves on to M
    step(tbl[14], 1, 0, 0, 0);
    step(tbl[0], 1, 1, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);

    // reset with add in E, M and W
    step(tbl[0], 1, 0, 0, 0);
    step(tbl[0], 1, 0, 0, 0);
    step(tbl[0], 1, 0, 0, 0);
    mid_reset("midrst");

    // five valid instructions, two flushed
    step(tbl[0], 1, 0, 0, 0);
    step(tbl[7], 1, 1, 0, 0);
    step(tbl[1], 1, 0, 0, 0);
    step(tbl[3], 1, 1, 0, 0);
    step(tbl[19], 1, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf.retired", 32'(bus.retired_cnt), 32'd3);
    chk("perf.flushed", 32'(bus.flush_cnt),   32'd2);
`else
    chk("perf.retired", 32'(bus.retired_cnt), 32'd0);
    chk("perf.flushed", 32'(bus.flush_cnt),   32'd0);
`endif

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      step(tbl[$urandom_range(NTBL - 1)], ($urandom_range(7) != 0), ($urandom_range(5) == 0),
           1'($urandom), 1'($urandom));
    end
    nop(0, 0); nop(0, 0); nop(0, 0);

    @(negedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
Pipelined successor to the single-cycle combinational controller. Decodes op/func3/func7 in the Decode stage and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. Supports bubble insertion (flush) and resolves branches and jumps in Execute. Sits beside the 5-stage datapath; the hazard unit drives flush_e.

Parameters:
ALUC_W, 3, ALUControl width; encodings below are zero-extended when ALUC_W > 3.
IMM_W, 3, ImmSrc width; encodings zero-extended.
CNT_W, 32, perf counter width (used only with PIPE_CTRL_PERF_EN).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
op_d  in  7  opcode of the instruction in D
func3_d  in  3  funct3 of the instruction in D
func7_d  in  7  funct7 of the instruction in D
valid_d  in  1  instruction in D is real (not a bubble)
flush_e  in  1  load a bubble into ID/EX on this edge
zero_e  in  1  ALU zero flag in E
lt_e  in  1  ALU less-than result in E (slt/sltu per ALUControl)
imm_src_d  out  IMM_W  immediate format, combinational from D
alu_control_e  out  ALUC_W  registered
alu_src_e  out  1  registered
jalr_e  out  1  registered; selects the rs1+imm target
pc_src_e  out  1  combinational: redirect the PC
result_src_e0  out  1  bit0 of ResultSrc in E (load-use detection)
reg_write_m  out  1  registered
mem_write_m  out  1  registered
result_src_m  out  2  registered
reg_write_w  out  1  registered
result_src_w  out  2  registered
retired_cnt  out  CNT_W  feature only
flush_cnt  out  CNT_W  feature only

Behaviour:
- Decode (combinational, D): default is all zero. Class rules:
  - R: RegWrite=1. func7|func3: add 010, sub 110, and 000, or 001, slt 100, sltu 111.
  - Load (0000011): RegWrite=1, ResultSrc=01, ALUSrc=1.
  - I (0010011): ALUSrc=1, RegWrite=1. addi 010, xori 011, ori 001, slti 100. sltiu gives ALUControl 111 with ImmSrc 101.
  - Jalr: Jalr=1, ALUSrc=1, ResultSrc=10, RegWrite=1.
  - S: ImmSrc=001, ALUSrc=1, MemWrite=1.
  - J: ResultSrc=10, ImmSrc=011, RegWrite=1, Jump=1.
  - B: Branch=1, ImmSrc=010. beq/bne ALUControl 110; blt/bge ALUControl 111.
  - U (0110111): ResultSrc=11, ImmSrc=100, RegWrite=1.
  - Unknown opcode: all zero, and the instruction is treated as invalid (valid forced to 0).
- All control outputs are gated by valid. A stage with valid=0 drives RegWrite, MemWrite, Branch, Jump and Jalr as 0.
- ID/EX register (also holds func3 and valid):
  - on flush_e=1, clears to all-zero;
  - otherwise loads the decoded D bundle every cycle.
  - There is no stall input: freezing D is done upstream at the IF/ID register.
- EX/MEM and MEM/WB registers advance every cycle unconditionally.
- Branch resolve in E:
  - taken = beq: zero_e; bne: !zero_e; blt: lt_e; bge: !lt_e; other func3: 0.
  - pc_src_e = valid_e & ((branch_e & taken) | jump_e | jalr_e).
- Latency: decode→E is 1 edge; E→M is 1 edge; M→W is 1 edge.
- rst asserted at any time: every pipeline register, and so every registered output, is 0 immediately. pc_src_e=0. Counters are 0.
- rst has priority over flush_e.
- flush_e on the same cycle that pc_src_e=1: the redirecting instruction itself still moves to M; only the incoming D instruction is bubbled.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: retired_cnt increments on each edge where valid_w=1. flush_cnt increments on each edge where flush_e=1 and valid_d=1. Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset: rst=1 mid-stream with add in E/M/W → all registered outputs 0 asynchronously, before the next edge.
- add x (op 0110011, f3 000, f7 0) with valid_d=1:
  - edge 1 → alu_control_e=010, pc_src_e=0;
  - edge 2 → reg_write_m=1;
  - edge 3 → reg_write_w=1, result_src_w=00.
- beq (op 1100011, f3 000) in E:
  - zero_e=1 → pc_src_e=1;
  - zero_e=0 → 0;
  - bge (f3 101) with lt_e=0 → 1.
- lw decoded, then flush_e=1 on the next edge → E holds the bubble: result_src_e0=0, reg_write_m=0 one cycle later.
- jal, then op 1111111 (unknown):
  - jal → pc_src_e=1, result_src_w=10 two edges later;
  - unknown op → all outputs 0, and retired_cnt does not increment for it.
- With PIPE_CTRL_PERF_EN: 5 valid instructions, 2 of them flushed → retired_cnt=3, flush_cnt=2.
